// File: rtl/sw_cond_pkg.sv
// Shared types and constants for the pushbutton conditioner.
//   NUM_SW      : number of pushbutton channels
//   sw_state_e  : per-channel press/repeat state
//   cnt_width() : counter width that holds 0..n-1 (at least one bit)
package sw_cond_pkg;

  localparam int unsigned NUM_SW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } sw_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_chan.sv
// One pushbutton channel: 2-flop synchronizer, debounce, press/auto-repeat FSM.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   i_raw     : asynchronous raw pushbutton bit
//   o_pulse   : one-cycle pulse on press and on each auto-repeat
//   o_held    : debounced pressed level
module sw_chan
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000,
  parameter bit          REP_EN     = 1'b0,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_held
);

  localparam int unsigned DEB_W    = cnt_width(DEB_CYCLES);
  localparam int unsigned HOLD_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

  logic              r_sync0;
  logic              r_sync1;
  logic              r_held;
  logic [DEB_W-1:0]  r_deb_cnt;
  sw_state_e         r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_pulse;

  logic              w_held_nxt;
  logic [DEB_W-1:0]  w_deb_nxt;
  logic              w_rise;
  logic              w_fall;
  sw_state_e         w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_pulse_nxt;

  // Synchronizer; polarity is folded in at the input so a cleared
  // synchronizer reads as "released" and cannot fake a press after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_raw ^ ACTIVE_LOW;
      r_sync1 <= r_sync0;
    end
  end

  // Debounce: count consecutive cycles the sampled level disagrees with held.
  always_comb begin
    w_held_nxt = r_held;
    w_deb_nxt  = '0;
    if (r_sync1 != r_held) begin
      if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        w_held_nxt = r_sync1;
      end else begin
        w_deb_nxt = r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // Edges taken from the next held value so the press pulse lands with held.
  assign w_rise = w_held_nxt & ~r_held;
  assign w_fall = ~w_held_nxt & r_held;

  // Press / repeat FSM; release is tested first so it beats a due repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_pulse_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == HOLD_W'(REP_DELAY - 1)) begin
          // Without repeat enabled the counter just saturates here.
          if (REP_EN) begin
            w_state_nxt = REPEAT;
            w_pulse_nxt = 1'b1;
            w_hold_nxt  = '0;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == HOLD_W'(REP_PERIOD - 1)) begin
          w_pulse_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held     <= 1'b0;
      r_deb_cnt  <= '0;
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_held     <= w_held_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_pulse    <= w_pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule

// File: rtl/sw_conditioner.sv
// Four-channel pushbutton conditioner: debounced levels plus press/repeat pulses.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   i_raw_sw[3:0] : asynchronous raw pushbuttons, channel 0..3
//   o_sw0..o_sw3  : one-cycle press/repeat pulses per channel
//   o_held[3:0]   : debounced pressed level per channel
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned       DEB_CYCLES = 500000,
  parameter int unsigned       REP_DELAY  = 25000000,
  parameter int unsigned       REP_PERIOD = 5000000,
  parameter logic [NUM_SW-1:0] REP_MASK   = 4'b0110,
  parameter bit                ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] i_raw_sw,
  output logic              o_sw0,
  output logic              o_sw1,
  output logic              o_sw2,
  output logic              o_sw3,
  output logic [NUM_SW-1:0] o_held
);

  logic [NUM_SW-1:0] w_sw;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    sw_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .REP_EN     (REP_MASK[g]),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (i_raw_sw[g]),
      .o_pulse (w_sw[g]),
      .o_held  (o_held[g])
    );
  end

  assign o_sw0 = w_sw[0];
  assign o_sw1 = w_sw[1];
  assign o_sw2 = w_sw[2];
  assign o_sw3 = w_sw[3];

endmodule

// File: doc/sw_conditioner.md
SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a switch level change (legal range 2 or more).
REQ-002 Parameter REP_DELAY, default 25000000, hold cycles after the press pulse before the first auto-repeat pulse (legal range 1 or more).
REQ-003 Parameter REP_PERIOD, default 5000000, cycles between successive auto-repeat pulses (legal range 1 or more).
REQ-004 Parameter REP_MASK, default 4'b0110, per-channel auto-repeat enable; bit N maps to channel N.
REQ-005 Parameter ACTIVE_LOW, default 1; 1 means raw input 0 = pressed.
REQ-006 clk  input  1  single system clock; all logic is synchronous to its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 i_raw_sw  input  4  asynchronous raw pushbuttons, channel 0..3.
REQ-009 o_sw0..o_sw3  output  1 each  one-cycle press/repeat pulses; these feed the clock top-level i_sw0..i_sw3.
REQ-010 o_held  output  4  debounced pressed level, one bit per channel.

Function
REQ-011 Each channel SHALL pass its raw bit through a 2-flop synchronizer, then invert it if ACTIVE_LOW=1, giving sampled level s.
REQ-012 The debounce counter SHALL increment while s differs from held and clear to 0 whenever s equals held.
REQ-013 When s differs from held and the counter equals DEB_CYCLES-1, held SHALL take the value of s and the counter SHALL clear.
REQ-014 Latency: take edge 0 as the edge that first samples the pressed raw level; held and the press pulse SHALL assert after edge DEB_CYCLES+1.
REQ-015 A bounce that returns to the held level before the count completes SHALL clear the counter and produce no output.
REQ-016 Per-channel FSM states SHALL be IDLE, PRESSED and REPEAT.
REQ-017 IDLE to PRESSED: on held rising; o_swN SHALL pulse for exactly one cycle and the hold counter SHALL clear.
REQ-018 PRESSED to REPEAT: when the hold counter reaches REP_DELAY-1 and REP_MASK[N]=1; one o_swN pulse is issued and the hold counter clears.
REQ-019 REPEAT: one o_swN pulse SHALL issue every REP_PERIOD cycles while held remains 1.
REQ-020 PRESSED and REPEAT to IDLE: on held falling; no pulse is issued and the hold counter clears.
REQ-021 If a release and a repeat pulse fall due on the same edge, the release SHALL win and no pulse is issued.
REQ-022 With REP_MASK[N]=0 the channel SHALL stay in PRESSED until release, so each press gives exactly one pulse.
REQ-023 Channels SHALL be fully independent; simultaneous presses produce simultaneous pulses with no arbitration.
REQ-024 Counter widths SHALL be $clog2 of the maximum count and SHALL never wrap; the hold counter saturates at REP_DELAY-1.

Reset
REQ-025 On rst=1 at a clock edge, the following SHALL clear to 0: synchronizer flops, counters, held, all o_sw outputs and o_held; the FSM goes to IDLE.
REQ-026 Reset mid-hold: a button still pressed after reset SHALL be treated as a new press, pulsing DEB_CYCLES+1 edges after rst deasserts (plus synchronizer fill).
REQ-027 No output pulse SHALL be generated on the cycle rst deasserts.

Structure
REQ-028 Package sw_cond_pkg SHALL hold the channel-state enum (IDLE, PRESSED, REPEAT) and the NUM_SW=4 constant.
REQ-029 One sub-module, sw_chan, SHALL implement the synchronizer, debounce and FSM for a single channel.
REQ-030 The top level SHALL instantiate sw_chan four times and pass the channel's REP_MASK bit to each instance.
REQ-031 Target size is 120-400 lines of RTL in total.

Verification
Bench parameters: DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5, REP_MASK=4'b0110, ACTIVE_LOW=1.
REQ-032 Clean press of ch0 held for 40 cycles -> exactly one o_sw0 pulse, after edge 5; o_held[0]=1 until 5 edges after release.
REQ-033 ch1 glitching low 3 cycles / high 1, repeated 10 times -> no o_sw1 pulse and o_held[1] stays 0.
REQ-034 ch2 held for 60 cycles -> pulses at press, press+20, press+25, press+30 and so on; none after release.
REQ-035 ch0 and ch3 pressed on the same cycle -> o_sw0 and o_sw3 pulse on the same cycle; ch3 gives no repeats.
REQ-036 rst asserted at press+10 on ch1 with the button kept held -> all outputs 0 during reset, then one new pulse after debounce completes.
REQ-037 ch2 released on the edge its repeat falls due -> no pulse, FSM returns to IDLE.
